piggy_txn_arbiter: RTL and testbench

//  Collects one-cycle coin/withdraw pulses from the per-button edge detectors.

---
 rtl/piggy_txn_arbiter.sv | 99 +++++++++
 tb/tb_piggy_txn_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/piggy_txn_arbiter.sv
// piggy_txn_arbiter: shares one balance-update datapath between a priority withdraw and round-robin coin requests
module piggy_txn_arbiter #(
   parameter int          NUM_REQ  = 4,
   parameter int          BAL_W    = 16,
   parameter int          MAX_BAL  = 9999,
   parameter logic [63:0] COIN_VAL = 64'h0000_0000_190A_0501
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] i_req_pulse,
   input  logic               i_wd_pulse,
   input  logic [BAL_W-1:0]   i_wd_amt,
   output logic [BAL_W-1:0]   o_balance,
   output logic [NUM_REQ-1:0] o_grant,
   output logic               o_txn_done,
   output logic               o_sat_flag,
   output logic               o_reject,
   output logic               o_drop_err,
   output logic               o_busy
);
   localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
   typedef enum logic {IDLE, APPLY} state_t;
   state_t r_state, w_state_nx;
   logic [NUM_REQ-1:0] r_pend, r_grant, w_clr;
   logic [BAL_W-1:0] r_bal, r_wd_amt;
   logic [PW-1:0] r_rr, r_sel, w_pick;
   logic [7:0] r_val, w_val;
   logic [BAL_W:0] w_sum;
   logic r_wd_pend, r_sel_wd, r_txn, r_sat, r_rej, r_drop, w_wd_clr, w_found;
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_val   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         int idx;
         idx = (int'(r_rr) + k) % NUM_REQ;
         if (!w_found && r_pend[idx]) begin
            w_found = 1'b1;
            w_pick  = idx[PW-1:0];
            w_val   = COIN_VAL[8*idx +: 8];
         end
      end
      w_state_nx = (r_state == IDLE && (r_wd_pend || w_found)) ? APPLY : IDLE;
      w_clr      = (r_state == APPLY && !r_sel_wd) ? NUM_REQ'(1) << r_sel : '0;
      w_wd_clr   = r_state == APPLY && r_sel_wd;
      w_sum      = {1'b0, r_bal} + (BAL_W+1)'(r_val);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_pend    <= '0;
         r_wd_pend <= 1'b0;
         r_wd_amt  <= '0;
         r_bal     <= '0;
         r_rr      <= '0;
         r_sel     <= '0;
         r_sel_wd  <= 1'b0;
         r_val     <= '0;
         r_grant   <= '0;
         r_txn     <= 1'b0;
         r_sat     <= 1'b0;
         r_rej     <= 1'b0;
         r_drop    <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_pend    <= (r_pend & ~w_clr) | i_req_pulse;
         r_wd_pend <= (r_wd_pend & ~w_wd_clr) | i_wd_pulse;
         if (i_wd_pulse && !(r_wd_pend && !w_wd_clr)) r_wd_amt <= i_wd_amt;
         r_drop    <= |(i_req_pulse & r_pend & ~w_clr) | (i_wd_pulse & r_wd_pend & ~w_wd_clr);
         r_grant   <= '0;
         r_txn     <= 1'b0;
         r_sat     <= 1'b0;
         r_rej     <= 1'b0;
         if (r_state == IDLE) begin
            r_sel_wd <= r_wd_pend;
            r_sel    <= w_pick;
            r_val    <= w_val;
         end else begin
            r_txn <= 1'b1;
            if (r_sel_wd) begin
               if (r_wd_amt > r_bal) r_rej <= 1'b1;
               else r_bal <= r_bal - r_wd_amt;
            end else begin
               r_grant <= w_clr;
               r_rr    <= (r_sel == PW'(NUM_REQ-1)) ? '0 : r_sel + 1'b1;
               r_sat   <= w_sum > (BAL_W+1)'(MAX_BAL);
               r_bal   <= (w_sum > (BAL_W+1)'(MAX_BAL)) ? BAL_W'(MAX_BAL) : w_sum[BAL_W-1:0];
            end
         end
      end
   end
   assign o_balance  = r_bal;
   assign o_grant    = r_grant;
   assign o_txn_done = r_txn;
   assign o_sat_flag = r_sat;
   assign o_reject   = r_rej;
   assign o_drop_err = r_drop;
   assign o_busy     = |r_pend || r_wd_pend || r_state != IDLE;
endmodule

// File: tb/tb_piggy_txn_arbiter.sv
// tb_piggy_txn_arbiter: directed and random stimulus checked every cycle against a behavioural model
module tb_piggy_txn_arbiter;
   localparam int N = 4, BW = 16, MAX = 100;
   logic clk = 0, rst = 1, wd = 0;
   logic [N-1:0] req = '0;
   logic [BW-1:0] amt = '0;
   logic [BW-1:0] balance;
   logic [N-1:0] grant;
   logic txn_done, sat_flag, reject, drop_err, busy;
   int checks = 0, errors = 0;
   int coin[N] = '{1, 5, 10, 25};
   bit [N-1:0] m_pend, e_grant;
   bit m_wd, m_apply, e_txn, e_sat, e_rej, e_drop;
   int m_amt, m_bal, m_rr, m_choice;
   piggy_txn_arbiter #(.NUM_REQ(N), .BAL_W(BW), .MAX_BAL(MAX)) dut (
      .clk(clk), .rst(rst), .i_req_pulse(req), .i_wd_pulse(wd), .i_wd_amt(amt),
      .o_balance(balance), .o_grant(grant), .o_txn_done(txn_done), .o_sat_flag(sat_flag),
      .o_reject(reject), .o_drop_err(drop_err), .o_busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask
   // One clock edge of the specified behaviour: serve the held transaction, capture pulses, pick the next.
   task automatic model_update();
      int pick, clr_c, s;
      bit clr_wd, held;
      e_grant = '0; e_txn = 0; e_sat = 0; e_rej = 0; e_drop = 0;
      if (rst) begin
         m_pend = '0; m_wd = 0; m_amt = 0; m_rr = 0; m_bal = 0; m_apply = 0;
         return;
      end
      pick = -2;
      if (!m_apply) begin
         if (m_wd) pick = -1;
         else for (int k = 0; k < N; k++) if (pick == -2 && m_pend[(m_rr + k) % N]) pick = (m_rr + k) % N;
      end
      clr_c = -2; clr_wd = 0;
      if (m_apply) begin
         e_txn = 1;
         if (m_choice < 0) begin
            if (m_amt > m_bal) e_rej = 1; else m_bal -= m_amt;
            clr_wd = 1;
         end else begin
            s = m_bal + coin[m_choice];
            if (s > MAX) begin m_bal = MAX; e_sat = 1; end else m_bal = s;
            e_grant = N'(1) << m_choice;
            m_rr = (m_choice + 1) % N;
            clr_c = m_choice;
         end
      end
      for (int i = 0; i < N; i++) begin
         held = m_pend[i] && i != clr_c;
         if (req[i] && held) e_drop = 1;
         m_pend[i] = held || req[i];
      end
      held = m_wd && !clr_wd;
      if (wd && held) e_drop = 1;
      else if (wd) m_amt = int'(amt);
      m_wd = held || wd;
      if (m_apply) m_apply = 0;
      else if (pick != -2) begin m_apply = 1; m_choice = pick; end
   endtask
   task automatic step(input logic r, input logic [N-1:0] rq, input logic w, input logic [BW-1:0] a);
      rst = r; req = rq; wd = w; amt = a;
      @(posedge clk);
      model_update();
      @(negedge clk);
      chk("balance", balance, m_bal);
      chk("grant", grant, e_grant);
      chk("txn_done", txn_done, e_txn);
      chk("sat_flag", sat_flag, e_sat);
      chk("reject", reject, e_rej);
      chk("drop_err", drop_err, e_drop);
      chk("busy", busy, (|m_pend) || m_wd || m_apply);
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, '0, 0, '0);
   endtask
   int exp2[4] = '{1, 6, 16, 41};
   initial begin
      step(1, '0, 0, '0);
      step(1, '0, 0, '0);
      chk("rst_balance", balance, 0);
      chk("rst_busy", busy, 0);
      step(0, 4'b0100, 0, '0);
      idle(2);
      chk("t1_balance", balance, 10);
      chk("t1_grant", grant, 4'b0100);
      chk("t1_txn", txn_done, 1);
      chk("t1_model", m_bal, 10);
      step(1, '0, 0, '0);
      step(0, 4'b1111, 0, '0);
      for (int k = 2; k <= 9; k++) begin
         idle(1);
         if (k % 2 == 1) begin
            chk("t2_balance", balance, exp2[(k-3)/2]);
            chk("t2_grant", grant, 1 << ((k-3)/2));
         end
      end
      step(0, 4'b0001, 1, 16'd1);
      idle(2);
      chk("t3_wd_grant", grant, 0);
      chk("t3_wd_balance", balance, 40);
      chk("t3_wd_txn", txn_done, 1);
      idle(2);
      chk("t3_coin_grant", grant, 4'b0001);
      chk("t3_coin_balance", balance, 41);
      step(0, '0, 1, 16'd50);
      idle(2);
      chk("t4_reject", reject, 1);
      chk("t4_balance", balance, 41);
      step(0, '0, 1, 16'd41);
      idle(2);
      chk("t4_exact_reject", reject, 0);
      chk("t4_exact_balance", balance, 0);
      step(0, '0, 1, 16'd0);
      idle(2);
      chk("t4_zero_txn", txn_done, 1);
      chk("t4_zero_reject", reject, 0);
      step(0, 4'b1000, 0, '0);
      step(0, 4'b1000, 0, '0);
      chk("t5_drop", drop_err, 1);
      idle(1);
      chk("t5_balance", balance, 25);
      idle(2);
      chk("t5_single", txn_done, 0);
      chk("t5_single_bal", balance, 25);
      for (int j = 0; j < 4; j++) begin
         step(0, 4'b1000, 0, '0);
         idle(2);
         chk("t5_sat_balance", balance, (50 + 25*j > MAX) ? MAX : 50 + 25*j);
         chk("t5_sat_flag", sat_flag, j == 3);
         idle(1);
      end
      step(0, 4'b0100, 0, '0);
      idle(1);
      step(1, '0, 0, '0);
      chk("t6_balance", balance, 0);
      chk("t6_busy", busy, 0);
      chk("t6_txn", txn_done, 0);
      for (int c = 0; c < 3000; c++) begin
         logic [N-1:0] rq;
         for (int i = 0; i < N; i++) rq[i] = $urandom_range(0, 5) == 0;
         step($urandom_range(0, 499) == 0, rq, $urandom_range(0, 9) == 0, BW'($urandom_range(0, 120)));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
